uart_rx_engine: RTL and testbench

UART_RX_ENGINE -- requirements
Module: uart_rx_engine

---
 rtl/uart_rx_engine.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver: synchronizes rx_i, votes each bit at mid-bit and
// reports one byte per frame with parity, framing and break status.
module uart_rx_engine #(
  parameter int OSR = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        rx_enable_i,
  input  logic [15:0] baud_div_i,
  input  logic        parity_en_i,
  input  logic        parity_odd_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        break_o,
  output logic        rx_idle_o
);

  localparam int MID = OSR / 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_nxt;
  logic        rx_meta, rx_s, rx_s_d;
  logic [15:0] div_cnt;
  logic [4:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [1:0]  votes;
  logic [7:0]  sh_reg;
  logic        par_en_q, par_odd_q, par_vote_q, par_err_q, brk_lock;
  logic        tick, rx_fall, start_ok, vote_now, bit_end, vote;
  logic        start_edge, capture;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Comparing with >= lets a shrinking baud_div_i take effect at the next compare.
  assign tick     = (div_cnt >= baud_div_i);
  assign rx_fall  = rx_s_d & ~rx_s;
  assign start_ok = rx_enable_i & rx_fall & ~brk_lock;
  assign vote_now = tick && (tick_cnt == 5'(MID + 1));
  assign bit_end  = tick && (tick_cnt == 5'(OSR - 1));
  assign vote     = majority(votes[1], votes[0], rx_s);
  assign rx_idle_o = (state == IDLE);

  always_comb begin
    state_nxt  = state;
    start_edge = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt  = START;
          start_edge = 1'b1;
        end
      end
      START: begin
        if (vote_now && vote) state_nxt = IDLE;
        else if (bit_end)     state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == 3'd7) state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        // Leave at the vote, not the bit end, so a back-to-back start edge is caught.
        if (vote_now) begin
          capture = 1'b1;
          if (start_ok) begin
            state_nxt  = START;
            start_edge = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rx_enable_i) begin
      state_nxt  = IDLE;
      start_edge = 1'b0;
      capture    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_s_d   <= 1'b1;
      state    <= IDLE;
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
      par_odd_q <= 1'b0;
      par_vote_q <= 1'b0;
      par_err_q <= 1'b0;
      brk_lock <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
      state   <= state_nxt;

      if (start_edge)  div_cnt <= '0;
      else if (tick)   div_cnt <= '0;
      else             div_cnt <= div_cnt + 16'd1;

      if (start_edge || state == IDLE) tick_cnt <= '0;
      else if (tick) tick_cnt <= (tick_cnt == 5'(OSR - 1)) ? 5'd0 : tick_cnt + 5'd1;

      if (start_edge) bit_cnt <= '0;
      else if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;

      if (start_edge) begin
        par_en_q   <= parity_en_i;
        par_odd_q  <= parity_odd_i;
        par_vote_q <= 1'b0;
        par_err_q  <= 1'b0;
      end else if (state == PARITY && vote_now) begin
        par_vote_q <= vote;
        par_err_q  <= vote ^ (^sh_reg) ^ par_odd_q;
      end

      // After a break the line must be seen high for a tick before re-arming.
      if (capture && (sh_reg == 8'h00) && !vote && !(par_en_q && par_vote_q))
        brk_lock <= 1'b1;
      else if (state == IDLE && tick && rx_s)
        brk_lock <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tick && tick_cnt == 5'(MID - 1)) votes[1] <= rx_s;
    if (tick && tick_cnt == 5'(MID))     votes[0] <= rx_s;
    if (state == DATA && vote_now)       sh_reg   <= {vote, sh_reg[7:1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_valid_o   <= 1'b0;
      rx_data_o    <= 8'h00;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
    end else begin
      rx_valid_o <= capture;
      if (capture) begin
        rx_data_o    <= sh_reg;
        parity_err_o <= par_en_q & par_err_q;
        frame_err_o  <= ~vote;
        break_o      <= (sh_reg == 8'h00) & ~vote & ~(par_en_q & par_vote_q);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine at OSR=16, baud_div_i=0 (16 clocks per bit).
module tb_uart_rx_engine;

  localparam int BIT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        en = 1'b1;
  logic [15:0] div = 16'd0;
  logic        pen = 1'b0;
  logic        podd = 1'b0;
  logic [7:0]  data;
  logic        valid, perr, ferr, brk, idle;

  int total = 0;
  int bad = 0;
  int double_pulse = 0;
  logic valid_prev = 1'b0;
  logic [10:0] rec_q[$];

  always #5 clk = ~clk;

  uart_rx_engine #(.OSR(16)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .rx_enable_i(en), .baud_div_i(div),
    .parity_en_i(pen), .parity_odd_i(podd), .rx_data_o(data), .rx_valid_o(valid),
    .parity_err_o(perr), .frame_err_o(ferr), .break_o(brk), .rx_idle_o(idle)
  );

  always @(negedge clk) begin
    if (!rst && valid) rec_q.push_back({data, perr, ferr, brk});
    if (valid && valid_prev) double_pulse++;
    valid_prev = valid;
  end

  typedef struct {
    logic [7:0] d;
    logic       pen, podd, pbit, stopb;
    logic       epe, efe, ebr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par,
                            input logic pbit, input logic stopb);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (with_par) drive_bit(pbit);
    drive_bit(stopb);
  endtask

  task automatic idle_line(input int bits);
    rx = 1'b1;
    repeat (bits * BIT) @(negedge clk);
  endtask

  initial begin
    logic idle_ok;
    logic [10:0] r;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_flags", {perr, ferr, brk}, 3'b000);
    check("reset_idle", idle, 1'b1);
    idle_line(2);

    for (int v = 0; v < 8; v++) begin
      pen = vecs[v].pen;
      podd = vecs[v].podd;
      rec_q.delete();
      send_frame(vecs[v].d, vecs[v].pen, vecs[v].pbit, vecs[v].stopb);
      idle_line(3);
      check($sformatf("vec%0d_count", v), rec_q.size(), 1);
      r = (rec_q.size() > 0) ? rec_q[0] : 11'h7FF;
      check($sformatf("vec%0d_data", v), r[10:3], vecs[v].d);
      check($sformatf("vec%0d_perr", v), r[2], vecs[v].epe);
      check($sformatf("vec%0d_ferr", v), r[1], vecs[v].efe);
      check($sformatf("vec%0d_brk", v), r[0], vecs[v].ebr);
      check($sformatf("vec%0d_hold", v), data, vecs[v].d);
    end
    pen = 1'b0;
    podd = 1'b0;

    // Short glitch on the line: rejected as a false start.
    rec_q.delete();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_left_idle", idle, 1'b0);
    rx = 1'b1;
    idle_ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (idle) begin
        idle_ok = 1'b1;
        break;
      end
    end
    check("glitch_idle_return", idle_ok, 1'b1);
    idle_line(3);
    check("glitch_no_valid", rec_q.size(), 0);

    // Break: line held low for 12 bit times.
    rec_q.delete();
    rx = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    idle_line(4);
    check("break_count", rec_q.size(), 1);
    r = (rec_q.size() > 0) ? rec_q[0] : 11'h000;
    check("break_data", r[10:3], 8'h00);
    check("break_ferr", r[1], 1'b1);
    check("break_flag", r[0], 1'b1);

    // Reset during data bit 4 of 0xFF.
    rec_q.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (8) @(negedge clk);
    check("midframe_busy", idle, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_data", data, 8'h00);
    check("rst_mid_valid", valid, 1'b0);
    check("rst_mid_flags", {perr, ferr, brk}, 3'b000);
    check("rst_mid_idle", idle, 1'b1);
    repeat (5) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(1'b1);
    drive_bit(1'b1);
    idle_line(2);
    check("rst_mid_no_valid", rec_q.size(), 0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    idle_line(2);
    check("after_rst_count", rec_q.size(), 1);
    r = (rec_q.size() > 0) ? rec_q[0] : 11'h000;
    check("after_rst_data", r[10:3], 8'h5A);
    check("after_rst_flags", r[2:0], 3'b000);

    // Receiver disabled mid-frame.
    rec_q.delete();
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (8) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("disable_idle", idle, 1'b1);
    en = 1'b1;
    repeat (7) @(negedge clk);
    for (int i = 2; i < 8; i++) drive_bit(1'b1);
    drive_bit(1'b1);
    idle_line(2);
    check("disable_no_valid", rec_q.size(), 0);

    // Back-to-back frames with single stop bits.
    rec_q.delete();
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    idle_line(3);
    check("b2b_count", rec_q.size(), 2);
    r = (rec_q.size() > 0) ? rec_q[0] : 11'h000;
    check("b2b_first", r[10:3], 8'h11);
    check("b2b_first_flags", r[2:0], 3'b000);
    r = (rec_q.size() > 1) ? rec_q[1] : 11'h000;
    check("b2b_second", r[10:3], 8'h22);
    check("b2b_second_flags", r[2:0], 3'b000);

    check("valid_single_cycle", double_pulse, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
